tdc_multi_event: RTL and testbench
==================================

// Module: tdc_multi_event
// PURPOSE
// Parametrised start/stop time-to-digital converter for the muon-lifetime chain: a rising
// edge on start_in (coincidence) opens a window, a rising edge on stop_in (decay) closes it.
// Each closed or timed-out window produces a record {timeout, time}; records queue in an
// internal FWFT FIFO. Adds dead time, re-trigger mode, enable/abort, saturation, drop count.
// PARAMETERS
// CNT_WIDTH       32          internal cycle-counter width; must exceed clog2(TIMEOUT_CYCLES)
// OUT_WIDTH       16          time field width of each record
// TIMEOUT_CYCLES  50_000_000  window length in cycles before timeout (>=1)
// DEADTIME_CYCLES 100         cycles all edges are ignored after a record (0 = none)
// RETRIGGER       0           0: start edge while measuring ignored; 1: restarts window
// FIFO_DEPTH      16          record FIFO depth, power of 2, >=2
// PORTS
// clk         in   1              system clock, 100 MHz
// rst_n       in   1              asynchronous active-low reset
// enable      in   1              arm; low aborts any open window without a record
// clear       in   1              sync: empty FIFO, zero drop_count (FSM unaffected)
// start_in    in   1              coincidence level, synchronous to clk
// stop_in     in   1              stop level, synchronous to clk
// rd_en       in   1              pop head record when dout_valid
// dout        out  OUT_WIDTH+1    head record {timeout, time[OUT_WIDTH-1:0]}
// dout_valid  out  1              FIFO not empty
// fifo_count  out  clog2(D)+1     records held
// fifo_full   out  1              fifo_count == FIFO_DEPTH
// busy        out  1              FSM in MEASURE or DEAD
// drop_count  out  16             records lost to full FIFO, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset: FSM IDLE, counter 0, FIFO empty, dout 0, dout_valid/busy/fifo_full 0, counts 0.
//   Edge-detect history regs reset to 1: a level already high at release is not an edge.
// - Edge: rise = in & ~in_q, one-cycle registered history; detect is same-cycle.
// - FSM IDLE: start rise & enable -> MEASURE, counter <= 1. Stop rises ignored.
// - MEASURE, each cycle, priority order:
//   1 enable==0 -> IDLE, no record.
//   2 stop rise -> push {0, sat(counter)} -> DEAD. Value = edge-to-edge distance in cycles
//     (stop rise n cycles after start rise records n). Wins over simultaneous start rise.
//   3 counter == TIMEOUT_CYCLES -> push {1, all-ones} -> DEAD.
//   4 start rise & RETRIGGER==1 -> counter <= 1, stay.
//   5 else counter <= counter + 1.
// - sat(x) = x if x < 2^OUT_WIDTH else all-ones; flag stays 0 for a saturated stop.
// - DEAD: DEADTIME_CYCLES cycles (incl. entry cycle) ignoring all edges, then IDLE;
//   DEADTIME_CYCLES==0 transitions directly MEASURE->IDLE. enable low in DEAD -> IDLE.
// - FIFO FWFT: dout shows head whenever dout_valid; rd_en & dout_valid pops at the edge;
//   rd_en when empty ignored. Push is written 1 cycle after the closing edge cycle.
// - Push when full and no pop same cycle: record dropped, drop_count += 1 (saturating).
//   Push and pop same cycle when full: both happen, count unchanged, no drop.
// - clear wins over push/pop in the same cycle (that push is discarded, not counted).
// - Reset mid-window: window lost, all state as reset; no record emitted.
// TESTING (TIMEOUT_CYCLES=100, DEADTIME_CYCLES=4, FIFO_DEPTH=4, OUT_WIDTH=8)
// 1 start rise t, stop rise t+37 -> one record dout=9'h025, dout_valid=1, busy 0 after dead.
// 2 start, no stop -> at 100 cycles record 9'h1FF pushed; 4 dead cycles; stop then ignored.
// 3 OUT_WIDTH=8, stop at t+300 with TIMEOUT 1000 -> record 9'h0FF (flag 0).
// 4 six start/stop pairs, rd_en held 0 -> fifo_count=4, fifo_full=1, drop_count=2;
//   pop 4 -> records in arrival order, dout_valid 0.
// 5 RETRIGGER=1: start t, start t+10, stop t+30 -> 20; RETRIGGER=0 same stimulus -> 30.
// 6 enable dropped at t+5 of a window -> no record; rst_n low mid-window -> all outputs 0;
//   start_in held high through reset release -> no window opened.

Source files
------------

// File: rtl/tdc_multi_event.sv
// Start/stop TDC with dead time, re-trigger, abort, saturation and record FIFO.
// Ports: clk/rst_n, enable/clear, start_in/stop_in levels, FWFT record FIFO out.
module tdc_multi_event #(
  parameter int CNT_WIDTH       = 32,
  parameter int OUT_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int DEADTIME_CYCLES = 100,
  parameter int RETRIGGER       = 0,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         start_in,
  input  logic                         stop_in,
  input  logic                         rd_en,
  output logic [OUT_WIDTH:0]           dout,
  output logic                         dout_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         fifo_full,
  output logic                         busy,
  output logic [15:0]                  drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DT  = CNT_WIDTH'(DEADTIME_CYCLES);
  localparam logic [CNT_WIDTH:0]   SAT_LIM = (CNT_WIDTH+1)'(1) << OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_DEAD
  } state_t;

  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic start_q, stop_q;
  logic start_rise, stop_rise;
  logic push_now, push_q;
  logic [OUT_WIDTH:0] push_rec, push_rec_q;
  logic [OUT_WIDTH-1:0] sat_val;

  assign start_rise = start_in & ~start_q;
  assign stop_rise  = stop_in & ~stop_q;
  assign sat_val = ({1'b0, cnt_q} >= SAT_LIM) ? '1 : cnt_q[OUT_WIDTH-1:0];

  // History resets high so a level already up at release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      start_q <= start_in;
      stop_q  <= stop_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (enable && start_rise) state_d = S_MEAS;
      S_MEAS: begin
        if (!enable)
          state_d = S_IDLE;
        else if (stop_rise || cnt_q == TMO)
          state_d = (DEADTIME_CYCLES == 0) ? S_IDLE : S_DEAD;
      end
      S_DEAD: if (!enable || cnt_q >= DT) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cnt_q is the window length in MEASURE and the dead-time tally in DEAD.
  always_comb begin
    cnt_d    = '0;
    push_now = 1'b0;
    push_rec = '0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: if (enable && start_rise) cnt_d = ONE;
      S_MEAS: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (stop_rise) begin
          push_now = 1'b1;
          push_rec = {1'b0, sat_val};
          cnt_d    = ONE;
        end else if (cnt_q == TMO) begin
          push_now = 1'b1;
          push_rec = {1'b1, {OUT_WIDTH{1'b1}}};
          cnt_d    = ONE;
        end else if (start_rise && RETRIGGER != 0) begin
          cnt_d = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_DEAD: if (enable && cnt_q < DT) cnt_d = cnt_q + ONE;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q     <= 1'b0;
      push_rec_q <= '0;
    end else begin
      push_q     <= push_now;
      push_rec_q <= push_rec;
    end
  end

  logic [OUT_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt_f;
  logic pop, wr, drop;

  assign dout_valid = (cnt_f != '0);
  assign fifo_full  = (cnt_f == (AW+1)'(FIFO_DEPTH));
  assign fifo_count = cnt_f;
  assign dout = dout_valid ? mem[rptr] : '0;
  assign pop  = rd_en & dout_valid;
  // A full FIFO still accepts a push when the head leaves the same cycle.
  assign wr   = push_q & (~fifo_full | pop);
  assign drop = push_q & fifo_full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt_f      <= '0;
      drop_count <= '0;
    end else if (clear) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt_f      <= '0;
      drop_count <= '0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt_f <= cnt_f + (AW+1)'(1);
        2'b01:   cnt_f <= cnt_f - (AW+1)'(1);
        default: cnt_f <= cnt_f;
      endcase
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !clear) mem[wptr] <= push_rec_q;
  end

endmodule

// File: tb/tb_tdc_multi_event.sv
// Directed bench for tdc_multi_event: two instances (no-retrigger/T=100 and
// retrigger/T=1000) share stimulus; table of start/stop gaps plus corner sequences.
module tb_tdc_multi_event;

  logic clk = 1'b0;
  logic rst_n, enable, clear, start_in, stop_in, rd_en;
  logic [8:0] dout_a, dout_b;
  logic valid_a, valid_b, full_a, full_b, busy_a, busy_b;
  logic [2:0] cnt_a, cnt_b;
  logic [15:0] drop_a, drop_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdc_multi_event #(
    .CNT_WIDTH(32), .OUT_WIDTH(8), .TIMEOUT_CYCLES(100),
    .DEADTIME_CYCLES(4), .RETRIGGER(0), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .start_in(start_in), .stop_in(stop_in), .rd_en(rd_en),
    .dout(dout_a), .dout_valid(valid_a), .fifo_count(cnt_a),
    .fifo_full(full_a), .busy(busy_a), .drop_count(drop_a)
  );

  tdc_multi_event #(
    .CNT_WIDTH(32), .OUT_WIDTH(8), .TIMEOUT_CYCLES(1000),
    .DEADTIME_CYCLES(4), .RETRIGGER(1), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .start_in(start_in), .stop_in(stop_in), .rd_en(rd_en),
    .dout(dout_b), .dout_valid(valid_b), .fifo_count(cnt_b),
    .fifo_full(full_b), .busy(busy_b), .drop_count(drop_b)
  );

  typedef struct {
    int         gap;
    logic [8:0] exp_a;
    logic [8:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start rise in the current cycle, stop rise gap cycles later.
  task automatic pair(input int gap);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (gap - 1) step();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1,   9'h001, 9'h001};
    vecs[1] = '{37,  9'h025, 9'h025};
    vecs[2] = '{99,  9'h063, 9'h063};
    vecs[3] = '{100, 9'h064, 9'h064};
    vecs[4] = '{150, 9'h1FF, 9'h096};
    vecs[5] = '{254, 9'h1FF, 9'h0FE};
    vecs[6] = '{256, 9'h1FF, 9'h0FF};
    vecs[7] = '{300, 9'h1FF, 9'h0FF};

    rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
    start_in = 1'b0; stop_in = 1'b0; rd_en = 1'b0;
    repeat (3) step();
    chk("rst dout", 32'(dout_a), 0);
    chk("rst valid", 32'(valid_a), 0);
    chk("rst busy", 32'(busy_a), 0);
    chk("rst full", 32'(full_a), 0);
    chk("rst count", 32'(cnt_a), 0);
    chk("rst drop", 32'(drop_a), 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Basic stop at +37 with exact push latency and dead time.
    pair(37);
    chk("t1 valid c+1", 32'(valid_a), 0);
    step();
    chk("t1 valid c+2", 32'(valid_a), 1);
    chk("t1 dout", 32'(dout_a), 32'h025);
    chk("t1 busy dead", 32'(busy_a), 1);
    repeat (3) step();
    chk("t1 busy idle", 32'(busy_a), 0);
    pop1();
    chk("t1 popped", 32'(valid_a), 0);
    repeat (4) step();

    // Timeout at 100; stop at +102 lands in dead time and is ignored by A.
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (101) step();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    step();
    chk("t2 busy t+104", 32'(busy_a), 1);
    step();
    chk("t2 busy t+105", 32'(busy_a), 0);
    chk("t2 dout a", 32'(dout_a), 32'h1FF);
    chk("t2 count a", 32'(cnt_a), 1);
    chk("t2 dout b", 32'(dout_b), 32'h066);
    repeat (5) step();
    chk("t2 count a later", 32'(cnt_a), 1);
    pop1();
    chk("t2 empty a", 32'(cnt_a), 0);
    chk("t2 empty b", 32'(cnt_b), 0);
    repeat (4) step();

    for (int i = 0; i < 8; i++) begin
      pair(vecs[i].gap);
      repeat (8) step();
      chk($sformatf("v%0d dout a", i), 32'(dout_a), 32'(vecs[i].exp_a));
      chk($sformatf("v%0d dout b", i), 32'(dout_b), 32'(vecs[i].exp_b));
      chk($sformatf("v%0d count a", i), 32'(cnt_a), 1);
      chk($sformatf("v%0d busy", i), 32'({busy_a, busy_b}), 0);
      pop1();
      chk($sformatf("v%0d empty", i), 32'({valid_a, valid_b}), 0);
      repeat (2) step();
    end

    // Overflow: six records into depth 4, then drain in order and clear.
    for (int i = 0; i < 6; i++) begin
      pair(3 + i);
      repeat (8) step();
    end
    chk("t4 count", 32'(cnt_a), 4);
    chk("t4 full", 32'(full_a), 1);
    chk("t4 drop", 32'(drop_a), 2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4 pop%0d", i), 32'(dout_a), 32'(3 + i));
      pop1();
    end
    chk("t4 drained", 32'(valid_a), 0);
    chk("t4 drop kept", 32'(drop_a), 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4 clear drop", 32'(drop_a), 0);

    // Second start 10 cycles in: A ignores it, B restarts.
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (9) step();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (19) step();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    repeat (8) step();
    chk("t5 norettrig", 32'(dout_a), 32'h01E);
    chk("t5 retrig", 32'(dout_b), 32'h014);
    pop1();
    repeat (2) step();

    // Abort via enable low five cycles into the window.
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (4) step();
    enable = 1'b0;
    step();
    enable = 1'b1;
    chk("t6 abort busy", 32'({busy_a, busy_b}), 0);
    repeat (5) step();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    repeat (10) step();
    chk("t6 abort no rec", 32'({valid_a, valid_b}), 0);

    // Reset mid-window with a record queued; start held high through release.
    pair(10);
    repeat (8) step();
    chk("t6 pre-rst rec", 32'(cnt_a), 1);
    start_in = 1'b1;
    step();
    start_in = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("t6 rst dout", 32'(dout_a), 0);
    chk("t6 rst valid", 32'({valid_a, valid_b}), 0);
    chk("t6 rst count", 32'(cnt_a), 0);
    chk("t6 rst busy", 32'({busy_a, busy_b}), 0);
    start_in = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6 held start", 32'({busy_a, busy_b}), 0);
    start_in = 1'b0;
    step();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    repeat (5) step();
    chk("t6 no rec", 32'({valid_a, valid_b}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
